button_event_decoder: RTL and testbench

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

---
 rtl/button_event_decoder.sv | 117 +++++++++++
 tb/tb_button_event_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Button gesture decoder: turns a debounced button level into edge pulses, a press counter
// and short / long / double press classification pulses.
module button_event_decoder #(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic [7:0] press_count
);

  localparam int CW = 27;
  // cnt holds (edges since entry - 1), so the timeout edge is where cnt equals N-1
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          prev_q;
  logic          rise, fall;
  logic          short_next, long_next, double_next;

  assign rise = button_in & ~prev_q;
  assign fall = ~button_in & prev_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prev_q        <= button_in;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      long_press    <= 1'b0;
      double_press  <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      prev_q        <= button_in;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_next;
      long_press    <= long_next;
      double_press  <= double_next;
      if (rise) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  // Edges are tested before timeouts so an edge landing on the timeout cycle wins.
  always_comb begin
    state_next  = state_reg;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rise) state_next = PRESSED;
      end
      PRESSED: begin
        if (fall) begin
          state_next = WAIT_SECOND;
        end else if (cnt_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (fall) state_next = IDLE;
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_next = SECOND_PRESSED;
        end else if (cnt_reg == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          double_next = 1'b1;
          state_next  = IDLE;
        end else if (cnt_reg == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) begin
      cnt_next = '0;
    end else if (state_reg == PRESSED || state_reg == WAIT_SECOND ||
                 state_reg == SECOND_PRESSED) begin
      cnt_next = cnt_reg + 1'b1;
    end else begin
      cnt_next = '0;
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gestures plus random traffic, checked every cycle
// against a timestamp-based gesture model.
module tb_button_event_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button_in = 1'b0;
  logic       press_pulse, release_pulse, short_press, long_press, double_press;
  logic [7:0] press_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state: times of the press / first release currently being timed
  bit         m_prev = 1'b0;
  int         press_t = -1;
  int         release_t = -1;
  bit         second = 1'b0;
  bit         long_hold = 1'b0;
  bit         e_press, e_release, e_short, e_long, e_double;
  logic [7:0] e_count = 8'd0;

  int n_press, n_release, n_short, n_long, n_double;

  button_event_decoder #(.LONG_CYCLES(LONG), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step();
    bit b;
    bit rise, fall;
    b = button_in;
    e_press = 0; e_release = 0; e_short = 0; e_long = 0; e_double = 0;
    if (!reset) begin
      press_t = -1; release_t = -1; second = 0; long_hold = 0;
      e_count = 8'd0;
      m_prev = b;
      return;
    end
    rise = b && !m_prev;
    fall = !b && m_prev;
    m_prev = b;
    e_press = rise;
    e_release = fall;
    if (rise) e_count = e_count + 8'd1;
    if (rise) begin
      second = (release_t >= 0);
      release_t = -1;
      press_t = cyc;
    end else if (fall) begin
      if (long_hold) begin
        long_hold = 0;
      end else if (press_t >= 0) begin
        if (second) e_double = 1;
        else release_t = cyc;
        press_t = -1;
        second = 0;
      end
    end else begin
      if (press_t >= 0 && cyc - press_t == LONG) begin
        e_long = 1; long_hold = 1; press_t = -1; second = 0;
      end
      if (release_t >= 0 && cyc - release_t == GAP) begin
        e_short = 1; release_t = -1;
      end
    end
  endtask

  task automatic tick(input logic b, input logic r);
    button_in = b;
    reset = r;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    check("press_pulse",   8'(press_pulse),   8'(e_press));
    check("release_pulse", 8'(release_pulse), 8'(e_release));
    check("short_press",   8'(short_press),   8'(e_short));
    check("long_press",    8'(long_press),    8'(e_long));
    check("double_press",  8'(double_press),  8'(e_double));
    check("press_count",   press_count,       e_count);
    check("one_class", 8'((32'(short_press) + 32'(long_press) + 32'(double_press)) <= 1), 8'd1);
    n_press   += int'(press_pulse);
    n_release += int'(release_pulse);
    n_short   += int'(short_press);
    n_long    += int'(long_press);
    n_double  += int'(double_press);
  endtask

  task automatic hold(input logic b, input int n);
    repeat (n) tick(b, 1'b1);
  endtask

  task automatic start(input string name);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;
    $display("scenario %s", name);
  endtask

  task automatic report(input string name);
    $display("scenario %s done: press=%0d release=%0d short=%0d long=%0d double=%0d count=%0d",
             name, n_press, n_release, n_short, n_long, n_double, press_count);
  endtask

  initial begin
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;

    start("reset");
    check("reset_count", press_count, 8'd0);
    report("reset");

    start("short");
    hold(1'b1, 5); hold(1'b0, 15);
    check("short_n", 8'(n_short), 8'd1);
    check("short_rel", 8'(n_release), 8'd1);
    check("short_cnt", press_count, 8'd1);
    report("short");

    start("double");
    hold(1'b1, 5); hold(1'b0, 4); hold(1'b1, 5); hold(1'b0, 15);
    check("double_n", 8'(n_double), 8'd1);
    check("double_short", 8'(n_short), 8'd0);
    check("double_cnt", press_count, 8'd2);
    report("double");

    start("long");
    hold(1'b1, 30); hold(1'b0, 15);
    check("long_n", 8'(n_long), 8'd1);
    check("long_short", 8'(n_short + n_double), 8'd0);
    check("long_rel", 8'(n_release), 8'd1);
    report("long");

    start("fall_at_long");
    hold(1'b1, LONG); hold(1'b0, 15);
    check("edge_long_n", 8'(n_long), 8'd0);
    check("edge_long_short", 8'(n_short), 8'd1);
    report("fall_at_long");

    start("rise_at_gap");
    hold(1'b1, 5); hold(1'b0, GAP); hold(1'b1, 5); hold(1'b0, 15);
    check("edge_gap_double", 8'(n_double), 8'd1);
    check("edge_gap_short", 8'(n_short), 8'd0);
    report("rise_at_gap");

    start("gap_plus_one");
    hold(1'b1, 5); hold(1'b0, GAP + 1); hold(1'b1, 5); hold(1'b0, 15);
    check("gap1_short", 8'(n_short), 8'd2);
    check("gap1_double", 8'(n_double), 8'd0);
    report("gap_plus_one");

    start("reset_mid_press");
    hold(1'b1, 5);
    repeat (3) tick(1'b1, 1'b0);
    n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_double = 0;
    hold(1'b1, 25); hold(1'b0, 15);
    check("rst_press", 8'(n_press), 8'd0);
    check("rst_rel", 8'(n_release), 8'd1);
    check("rst_class", 8'(n_short + n_long + n_double), 8'd0);
    check("rst_cnt", press_count, 8'd0);
    report("reset_mid_press");

    start("wrap");
    repeat (256) begin
      hold(1'b1, 3); hold(1'b0, 12);
    end
    check("wrap_cnt", press_count, 8'd0);
    check("wrap_short", 8'(n_short == 256), 8'd1);
    report("wrap");

    start("random");
    repeat (300) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(1, 3)) tick($urandom_range(0, 1) == 1, 1'b0);
      end
      hold(1'b1, int'($urandom_range(1, 30)));
      hold(1'b0, int'($urandom_range(1, 16)));
    end
    hold(1'b0, 15);
    report("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
